// File: rtl/operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_loader_if
// Description : Bus bundle between the operand-entry logic and its user:
//               nibble entry buttons, commit controls, the two bank read
//               ports and the shadow-word status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_loader_if #(
    parameter int N  = 32,
    parameter int AW = 3
);
    logic [3:0]    nibble_i;
    logic          load_i;
    logic          commit_i;
    logic          bank_sel_i;
    logic [AW-1:0] waddr_i;
    logic [AW-1:0] raddra_i;
    logic [AW-1:0] raddrb_i;
    logic [N-1:0]  opea_o;
    logic [N-1:0]  opeb_o;
    logic [N-1:0]  shadow_o;
    logic [3:0]    nib_cnt_o;
    logic          full_o;
    logic          wr_done_o;

    // Design side
    modport slave (
        input  nibble_i, load_i, commit_i, bank_sel_i, waddr_i, raddra_i, raddrb_i,
        output opea_o, opeb_o, shadow_o, nib_cnt_o, full_o, wr_done_o
    );

    // Stimulus / consumer side
    modport master (
        output nibble_i, load_i, commit_i, bank_sel_i, waddr_i, raddra_i, raddrb_i,
        input  opea_o, opeb_o, shadow_o, nib_cnt_o, full_o, wr_done_o
    );
endinterface
`default_nettype wire

// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : operand_loader
// Description : Hex-nibble operand entry with debounced buttons. Nibbles are
//               shifted into a shadow word; a commit writes the shadow word
//               into operand bank A or B. Both banks have combinational read
//               ports for the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_loader #(
    parameter int N               = 32,
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    operand_loader_if.slave    bus
);
    localparam int       c_AW       = $clog2(DEPTH);
    localparam int       c_CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] c_NIBS   = 4'(N / 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // Button 0 = load, button 1 = commit. Raw inputs are assumed to be
    // already synchronous to clk_i.
    logic [1:0] w_raw;
    logic [1:0] w_pulse;
    logic       w_ld_p;
    logic       w_cm_p;

    assign w_raw  = {bus.commit_i, bus.load_i};
    assign w_ld_p = w_pulse[0];
    assign w_cm_p = w_pulse[1];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_deb
            logic            r_level;
            logic            r_level_d;
            logic            r_pulse;
            logic [c_CW-1:0] r_cnt;

            // Accept a new level only after DEBOUNCE_CYCLES consecutive
            // differing samples; emit one pulse on each rising level.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_pulse   <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    if (w_raw[g] != r_level) begin
                        if (r_cnt == c_CNT_MAX) begin
                            r_level <= ~r_level;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                    r_level_d <= r_level;
                    r_pulse   <= r_level & ~r_level_d;
                end
            end

            assign w_pulse[g] = r_pulse;
        end
    endgenerate

    state_t w_next;
    state_t r_state;
    logic   w_shift;
    logic   w_capture;
    logic   w_write;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and action strobes; commit takes priority over load, and
    // pulses seen during WRITE are dropped.
    always_comb begin
        w_next    = r_state;
        w_shift   = 1'b0;
        w_capture = 1'b0;
        w_write   = 1'b0;
        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (w_cm_p) begin
                    w_next    = S_WRITE;
                    w_capture = 1'b1;
                end else if (w_ld_p) begin
                    w_next  = S_ENTRY;
                    w_shift = 1'b1;
                end
            end
            S_WRITE: begin
                w_write = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    logic [N-1:0]    r_shadow;
    logic [3:0]      r_nib_cnt;
    logic            r_full;
    logic            r_wr_done;
    logic            r_sel;
    logic [c_AW-1:0] r_waddr;

    // Shadow word assembly, commit target capture and write-done flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shadow  <= '0;
            r_nib_cnt <= '0;
            r_full    <= 1'b0;
            r_wr_done <= 1'b0;
            r_sel     <= 1'b0;
            r_waddr   <= '0;
        end else begin
            r_wr_done <= w_write;
            if (w_capture) begin
                r_sel   <= bus.bank_sel_i;
                r_waddr <= bus.waddr_i;
            end
            if (w_write) begin
                r_shadow  <= '0;
                r_nib_cnt <= '0;
                r_full    <= 1'b0;
            end else if (w_shift) begin
                // Once full, keep shifting so the oldest digit drops out
                r_shadow <= {r_shadow[N-5:0], bus.nibble_i};
                if (r_nib_cnt != c_NIBS) begin
                    r_nib_cnt <= r_nib_cnt + 4'd1;
                end
                r_full <= (r_nib_cnt >= c_NIBS - 4'd1);
            end
        end
    end

    logic [N-1:0] r_bank_a [DEPTH];
    logic [N-1:0] r_bank_b [DEPTH];

    // Operand banks, written only in the WRITE state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank_a[i] <= '0;
                r_bank_b[i] <= '0;
            end
        end else if (w_write) begin
            if (r_sel) r_bank_b[r_waddr] <= r_shadow;
            else       r_bank_a[r_waddr] <= r_shadow;
        end
    end

    // Read ports return the pre-write word when reading the write address
    assign bus.opea_o    = r_bank_a[bus.raddra_i];
    assign bus.opeb_o    = r_bank_b[bus.raddrb_i];
    assign bus.shadow_o  = r_shadow;
    assign bus.nib_cnt_o = r_nib_cnt;
    assign bus.full_o    = r_full;
    assign bus.wr_done_o = r_wr_done;

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_loader
// Description : Self-checking bench for operand_loader with a word-level
//               reference model of the shadow register and both banks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_loader;
    localparam int N     = 32;
    localparam int DEPTH = 8;
    localparam int DC    = 4;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    operand_loader_if #(.N(N), .AW(AW)) bus ();

    operand_loader #(.N(N), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference model
    logic [31:0] m_bank [2][DEPTH];
    logic [31:0] m_shadow;
    int          m_cnt;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++)
                m_bank[b][a] = '0;
        m_shadow = '0;
        m_cnt    = 0;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".shadow"}, bus.shadow_o, m_shadow);
        check({tag, ".nib_cnt"}, 32'(bus.nib_cnt_o), 32'(m_cnt));
        check({tag, ".full"}, 32'(bus.full_o), 32'(m_cnt == 8));
    endtask

    task automatic check_banks(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            bus.raddra_i = 3'(a);
            bus.raddrb_i = 3'(a);
            #1;
            check({tag, ".bankA"}, bus.opea_o, m_bank[0][a]);
            check({tag, ".bankB"}, bus.opeb_o, m_bank[1][a]);
        end
    endtask

    // One full press/release of the load button
    task automatic load_digit(input logic [3:0] nib);
        bus.nibble_i = nib;
        bus.load_i   = 1'b1;
        repeat (6) @(negedge clk);
        bus.load_i   = 1'b0;
        repeat (6) @(negedge clk);
        m_shadow = {m_shadow[27:0], nib};
        if (m_cnt < 8) m_cnt++;
        check_status("load");
    endtask

    // Press/release of commit (optionally with load pressed at the same time)
    task automatic commit(input logic sel, input logic [2:0] addr, input logic with_load);
        int pulses;
        pulses = 0;
        bus.bank_sel_i = sel;
        bus.waddr_i    = addr;
        bus.commit_i   = 1'b1;
        bus.load_i     = with_load;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.wr_done_o) pulses++;
            if (i == 5) begin
                bus.commit_i = 1'b0;
                bus.load_i   = 1'b0;
            end
        end
        m_bank[sel][addr] = m_shadow;
        m_shadow = '0;
        m_cnt    = 0;
        check("commit.wr_done_pulses", 32'(pulses), 32'd1);
        check_status("commit");
    endtask

    // Load button glitch shorter than the debounce window
    task automatic glitch(input int len);
        bus.nibble_i = 4'($urandom_range(0, 15));
        bus.load_i   = 1'b1;
        repeat (len) @(negedge clk);
        bus.load_i   = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        bus.nibble_i   = '0;
        bus.load_i     = 1'b0;
        bus.commit_i   = 1'b0;
        bus.bank_sel_i = 1'b0;
        bus.waddr_i    = '0;
        bus.raddra_i   = '0;
        bus.raddrb_i   = '0;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1. reset state
        check_status("reset");
        check_banks("reset");

        // 2. eight digits then commit to A[3]
        for (int d = 1; d <= 8; d++) load_digit(4'(d));
        check("t2.shadow_const", bus.shadow_o, 32'h12345678);
        check("t2.full_const", 32'(bus.full_o), 32'd1);
        commit(1'b0, 3'd3, 1'b0);
        bus.raddra_i = 3'd3;
        #1 check("t2.bankA3_const", bus.opea_o, 32'h12345678);
        check_banks("t2");

        // 3. short pulse and fast toggling must not shift
        load_digit(4'hE);
        glitch(2);
        check_status("t3.pulse");
        for (int i = 0; i < 20; i++) begin
            bus.load_i = ~bus.load_i;
            @(negedge clk);
        end
        bus.load_i = 1'b0;
        repeat (6) @(negedge clk);
        check_status("t3.toggle");
        commit(1'b1, 3'd0, 1'b0);

        // 4. nine digits, oldest dropped, commit to B[7]
        for (int d = 1; d <= 9; d++) load_digit(4'(d));
        check("t4.nib_cnt_const", 32'(bus.nib_cnt_o), 32'd8);
        commit(1'b1, 3'd7, 1'b0);
        bus.raddrb_i = 3'd7;
        #1 check("t4.bankB7_const", bus.opeb_o, 32'h23456789);
        check_banks("t4");

        // 5. load and commit debounced on the same cycle: commit wins
        load_digit(4'hA);
        load_digit(4'hB);
        bus.nibble_i = 4'hC;
        commit(1'b1, 3'd2, 1'b1);
        bus.raddrb_i = 3'd2;
        #1 check("t5.bankB2_const", bus.opeb_o, 32'h000000AB);
        check_banks("t5");

        // Randomized entry / glitch / commit sequences
        for (int it = 0; it < 6; it++) begin
            int k;
            k = $urandom_range(0, 10);
            for (int d = 0; d < k; d++) begin
                if ($urandom_range(0, 2) == 0) begin
                    glitch($urandom_range(1, DC - 1));
                    check_status("rand.glitch");
                end
                load_digit(4'($urandom_range(0, 15)));
            end
            commit(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0);
            check_banks("rand");
        end

        // 6. asynchronous reset mid-cycle during entry
        load_digit(4'h5);
        load_digit(4'h6);
        load_digit(4'h7);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_status("t6.async_rst");
        check_banks("t6.async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // A commit from IDLE writes the zero word over existing data
        load_digit(4'h9);
        load_digit(4'h1);
        commit(1'b0, 3'd3, 1'b0);
        check_banks("t6.prewrite");
        commit(1'b0, 3'd3, 1'b0);
        bus.raddra_i = 3'd3;
        #1 check("t6.bankA3_zero", bus.opea_o, 32'h0);
        check_banks("t6.zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
